// File: rtl/dmem_arbiter.sv
// Two-port byte arbiter/sequencer in front of a 256x8 single-port data memory with registered read.
// Optional macro DMEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed port-0 priority.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_write_q, mem_write_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          busy_q, busy_d;
    logic          win1;

`ifdef DMEM_ARB_RR_EN
    logic          last_grant_q, last_grant_d;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        if (req0 && req1) begin
            win1 = ~last_grant_q;
        end else begin
            win1 = req1;
        end
    end
`else
    always_comb begin
        win1 = ~req0;
    end
`endif

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_write_d = 1'b0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef DMEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    id_d        = win1;
                    we_d        = win1 ? we1 : we0;
                    mem_addr_d  = win1 ? addr1 : addr0;
                    mem_din_d   = win1 ? wdata1 : wdata0;
                    mem_write_d = win1 ? we1 : we0;
                    gnt0_d      = ~win1;
                    gnt1_d      = win1;
                    state_d     = ST_ISSUE;
`ifdef DMEM_ARB_RR_EN
                    last_grant_d = win1;
`endif
                end
            end
            ST_ISSUE: begin
                // Memory samples the command at the edge ending this cycle.
                state_d = we_q ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                if (id_q) begin
                    rdata1_d  = mem_dout;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_dout;
                    rvalid0_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_write_q <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_write_q <= mem_write_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Reset to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_din   = mem_din_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 256x8 registered-read memory.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0;
    logic       req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr1 = '0, wdata1 = '0;
    logic       gnt0, rvalid0, gnt1, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_addr, mem_din;
    logic       mem_write, busy;
    logic [7:0] mem_dout = '0;

    int checks = 0;
    int failures = 0;

    logic [7:0] tb_mem [0:255];
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    // Preloaded image: 0x00 = 0xCA, everything else 0.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 8'h00;
            tb_mem[0] <= 8'hCA;
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            tb_mem[mem_addr] <= mem_din;
        end
        mem_dout <= tb_mem[mem_addr];
    end

    dmem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_write, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, rvalid0, rvalid1, mem_write, busy});
        end
        checks++;
        if ({rdata0, rdata1, mem_addr, mem_din} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 00000000", {rdata0, rdata1, mem_addr, mem_din});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        @(negedge clk);
        checks++;
        if ({gnt0, busy} !== 2'b11) begin
            failures++;
            $display("FAIL midrd_gnt: gnt0,busy=%b want 11", {gnt0, busy});
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rvalid0} !== 2'b10) begin
            failures++;
            $display("FAIL midrd_rdwait: busy,rvalid0=%b want 10", {busy, rvalid0});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_write, busy, mem_addr, mem_din, rdata0, rdata1} !== 38'h0) begin
            failures++;
            $display("FAIL midrd_async: outputs=%h want 0",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_write, busy, mem_addr, mem_din, rdata0, rdata1});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({rvalid0, busy} !== 2'b00) begin
                failures++;
                $display("FAIL midrd_after cyc%0d: rvalid0,busy=%b want 00", c, {rvalid0, busy});
            end
        end
        $display("test_reset_mid_read done");
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'h5A;
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, mem_write, mem_addr, mem_din} !== {3'b101, 8'h10, 8'h5A}) begin
            failures++;
            $display("FAIL wr_issue: gnt1,gnt0,we,addr,din=%b,%b,%b,%h,%h want 1,0,1,10,5a",
                     gnt1, gnt0, mem_write, mem_addr, mem_din);
        end
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt1, mem_write, busy} !== 3'b000) begin
            failures++;
            $display("FAIL wr_done: gnt1,mem_write,busy=%b want 000", {gnt1, mem_write, busy});
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        @(negedge clk);
        checks++;
        if ({gnt0, mem_write, mem_addr} !== {2'b10, 8'h10}) begin
            failures++;
            $display("FAIL rd_issue: gnt0,mem_write,addr=%b,%b,%h want 1,0,10", gnt0, mem_write, mem_addr);
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, rvalid0, busy} !== 3'b001) begin
            failures++;
            $display("FAIL rd_wait: gnt0,rvalid0,busy=%b want 001", {gnt0, rvalid0, busy});
        end
        @(negedge clk);
        checks++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== {2'b10, 8'h5A, 8'h00}) begin
            failures++;
            $display("FAIL rd_resp: rvalid0,rvalid1,rdata0,rdata1=%b,%b,%h,%h want 1,0,5a,00",
                     rvalid0, rvalid1, rdata0, rdata1);
        end
        @(negedge clk);
        checks++;
        if ({rvalid0, rdata0} !== {1'b0, 8'h5A}) begin
            failures++;
            $display("FAIL rd_hold: rvalid0,rdata0=%b,%h want 0,5a", rvalid0, rdata0);
        end
        $display("test_write_read done");
    endtask

    task automatic test_preload();
        logic [7:0] exp_data [2];
        exp_data[0] = 8'hCA;
        exp_data[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req0 = 1'b1; we0 = 1'b0; addr0 = 8'(k);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                checks++;
                if (mem_write !== 1'b0) begin
                    failures++;
                    $display("FAIL pre_nowrite rd%0d cyc%0d: mem_write=%b want 0", k, c, mem_write);
                end
                if (c == 1) begin
                    req0 = 1'b0;
                    checks++;
                    if (gnt0 !== 1'b1) begin
                        failures++;
                        $display("FAIL pre_gnt rd%0d: gnt0=%b want 1", k, gnt0);
                    end
                end
                if (c == 3) begin
                    checks++;
                    if ({rvalid0, rdata0} !== {1'b1, exp_data[k]}) begin
                        failures++;
                        $display("FAIL pre_data rd%0d: rvalid0,rdata0=%b,%h want 1,%h", k, rvalid0, rdata0, exp_data[k]);
                    end
                end
            end
            $display("preload read addr=%0h rdata0=%h", k, rdata0);
        end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h33;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, mem_write, mem_addr, mem_din} !== {3'b101, 8'h20, 8'h33}) begin
            failures++;
            $display("FAIL sim_first: gnt0,gnt1,we,addr,din=%b,%b,%b,%h,%h want 1,0,1,20,33",
                     gnt0, gnt1, mem_write, mem_addr, mem_din);
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt1, busy} !== 2'b00) begin
            failures++;
            $display("FAIL sim_gap: gnt1,busy=%b want 00", {gnt1, busy});
        end
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, mem_write, mem_addr} !== {3'b100, 8'h20}) begin
            failures++;
            $display("FAIL sim_second: gnt1,gnt0,we,addr=%b,%b,%b,%h want 1,0,0,20", gnt1, gnt0, mem_write, mem_addr);
        end
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rvalid1, rvalid0, rdata1} !== {2'b10, 8'h33}) begin
            failures++;
            $display("FAIL sim_resp: rvalid1,rvalid0,rdata1=%b,%b,%h want 1,0,33", rvalid1, rvalid0, rdata1);
        end
        $display("simultaneous: port1 read rdata1=%h", rdata1);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int last_gnt = -10;
        logic prev_mw = 1'b0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'hA0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            checks++;
            if (prev_mw && mem_write) begin
                failures++;
                $display("FAIL b2b_consec cyc%0d: mem_write high two cycles", c);
            end
            prev_mw = mem_write;
            if (gnt0) begin
                checks++;
                if ((n > 0 && c - last_gnt != 2) || mem_addr !== 8'(8'h30 + n) || mem_write !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_gnt %0d: spacing=%0d addr=%h we=%b want 2,%h,1",
                             n, c - last_gnt, mem_addr, mem_write, 8'(8'h30 + n));
                end
                last_gnt = c;
                n++;
                if (n < 4) begin
                    addr0 = 8'(8'h30 + n); wdata0 = 8'(8'hA0 + n);
                end else begin
                    req0 = 1'b0;
                end
            end
        end
        req0 = 1'b0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL b2b_timeout: grants=%0d want 4", n);
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tb_mem[8'h30 + i] !== 8'(8'hA0 + i)) begin
                failures++;
                $display("FAIL b2b_store %0d: mem=%h want %h", i, tb_mem[8'h30 + i], 8'(8'hA0 + i));
            end
        end
        $display("back_to_back: %0d writes issued", n);
    endtask

    task automatic test_arbitration();
        int ng = 0;
        int n0 = 0;
        int n1 = 0;
        int seq [4];
        int exp_seq [4];
`ifdef DMEM_ARB_RR_EN
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
        exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
        for (int i = 0; i < 4; i++) seq[i] = -1;
        pulse_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h50; wdata1 = 8'h22;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) begin
                checks++;
                failures++;
                $display("FAIL arb_both cyc%0d: gnt0 and gnt1 both high", c);
            end
            if (gnt0) begin
                seq[ng] = 0; ng++; n0++; addr0 = 8'(8'h40 + n0);
            end else if (gnt1) begin
                seq[ng] = 1; ng++; n1++; addr1 = 8'(8'h50 + n1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq[i] != exp_seq[i]) begin
                failures++;
                $display("FAIL arb_order grant%0d: port=%0d want %0d", i, seq[i], exp_seq[i]);
            end
            $display("arbitration grant%0d -> port %0d", i, seq[i]);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid_read();
        test_write_read();
        test_preload();
        test_simultaneous();
        test_back_to_back();
        test_arbitration();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
